// File: rtl/cpu_run_ctrl.sv
// Run/step/burst clock-enable controller for CPU bring-up: debounced conti key, slow tick divider.
// Optional breakpoint halt enabled by defining RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl #(
  parameter int unsigned DIV_SLOW   = 5_000_000,
  parameter int unsigned DIV_W      = 24,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PC_W       = 32
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             conti,
  input  logic             clkswitch,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [PC_W-1:0]  cpu_pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             cpu_ce,
  output logic             halted,
  output logic             step_ack,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             bp_hit
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_HALT  = 2'b11;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_SLOW - 1);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_BURST} state_t;

  state_t           state, state_nxt;
  logic             conti_s1, conti_s2, conti_deb, conti_pulse;
  logic [DEB_W-1:0] deb_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             bp_match;
  logic [CNT_W-1:0] remaining, rem_nxt;
  logic             ce_nxt, ack_nxt, bp_set, bp_clr;

  // Synchronise the key, then require DEB_CYCLES consecutive differing samples to flip the level
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      conti_s1    <= 1'b0;
      conti_s2    <= 1'b0;
      conti_deb   <= 1'b0;
      deb_cnt     <= '0;
      conti_pulse <= 1'b0;
    end else begin
      conti_s1    <= conti;
      conti_s2    <= conti_s1;
      conti_pulse <= conti_s2 & ~conti_deb & (deb_cnt == DEB_LAST);
      if (conti_s2 == conti_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt   <= '0;
        conti_deb <= conti_s2;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Slow tick divider, parked at zero while running at full rate
  assign tick = ~clkswitch | (div_cnt == DIV_LAST);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!clkswitch || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

`ifdef RUN_CTRL_BREAKPOINT_EN
  assign bp_match = bp_valid && (cpu_pc == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = bp_valid ^ (^cpu_pc) ^ (^bp_addr);
  assign bp_match  = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state     <= S_HALT;
      remaining <= '0;
      cpu_ce    <= 1'b0;
      halted    <= 1'b1;
      step_ack  <= 1'b0;
      cycle_cnt <= '0;
      bp_hit    <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      cpu_ce    <= ce_nxt;
      halted    <= (state_nxt == S_HALT);
      step_ack  <= ack_nxt;
      bp_hit    <= (bp_hit & ~bp_clr) | bp_set;
      if (ce_nxt && cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  // Next state and next registered outputs; a tick with a breakpoint match takes priority over ce
  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    ce_nxt    = 1'b0;
    ack_nxt   = 1'b0;
    bp_set    = 1'b0;
    bp_clr    = 1'b0;
    unique case (state)
      S_HALT: begin
        bp_clr = conti_pulse;
        if (mode == MODE_RUN) begin
          state_nxt = S_RUN;
        end else if (mode == MODE_STEP && conti_pulse) begin
          state_nxt = S_STEP;
        end else if (mode == MODE_BURST && conti_pulse && burst_len != '0) begin
          state_nxt = S_BURST;
          rem_nxt   = burst_len;
        end
      end
      S_RUN: begin
        if (mode != MODE_RUN) begin
          state_nxt = S_HALT;
        end else if (tick && bp_match) begin
          bp_set    = 1'b1;
          state_nxt = S_HALT;
        end else begin
          ce_nxt = tick;
        end
      end
      S_STEP: begin
        if (mode == MODE_HALT) begin
          state_nxt = S_HALT;
        end else if (tick) begin
          ce_nxt    = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_BURST: begin
        if (mode == MODE_HALT) begin
          state_nxt = S_HALT;
          rem_nxt   = '0;
        end else if (tick && bp_match) begin
          bp_set    = 1'b1;
          state_nxt = S_HALT;
          rem_nxt   = '0;
        end else if (tick) begin
          ce_nxt  = 1'b1;
          rem_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_nxt = S_HALT;
        end
      end
      default: state_nxt = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl (DIV_SLOW=4, CNT_W=4, DEB_CYCLES=16).
module tb_cpu_run_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned PC_W  = 32;

  logic             sys_clk = 1'b0;
  logic             rst = 1'b1;
  logic             conti = 1'b0;
  logic             clkswitch = 1'b0;
  logic [1:0]       mode = 2'b11;
  logic [CNT_W-1:0] burst_len = '0;
  logic [PC_W-1:0]  cpu_pc = '0;
  logic [PC_W-1:0]  bp_addr = '0;
  logic             bp_valid = 1'b0;
  logic             cpu_ce, halted, step_ack, bp_hit;
  logic [CNT_W-1:0] cycle_cnt;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int ce_seen, ack_seen, run_seen;
  int ce_at[$];

  cpu_run_ctrl #(.DIV_SLOW(4), .DIV_W(3), .DEB_CYCLES(16), .CNT_W(CNT_W), .PC_W(PC_W)) dut (
    .sys_clk(sys_clk), .rst(rst), .conti(conti), .clkswitch(clkswitch), .mode(mode),
    .burst_len(burst_len), .cpu_pc(cpu_pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .cpu_ce(cpu_ce), .halted(halted), .step_ack(step_ack), .cycle_cnt(cycle_cnt), .bp_hit(bp_hit)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance n cycles, sampling 1 time unit after each rising edge
  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
      cyc++;
      if (cpu_ce) begin ce_seen++; ce_at.push_back(cyc); end
      if (step_ack) ack_seen++;
      if (!halted) run_seen++;
    end
  endtask

  task automatic clear_counts();
    ce_seen = 0; ack_seen = 0; run_seen = 0; ce_at.delete();
  endtask

  task automatic press(input int hi, input int lo);
    conti = 1'b1; step_clk(hi);
    conti = 1'b0; step_clk(lo);
  endtask

  task automatic do_reset();
    rst = 1'b1; mode = 2'b11; conti = 1'b0; clkswitch = 1'b0;
    burst_len = '0; bp_valid = 1'b0; cpu_pc = '0; bp_addr = '0;
    step_clk(2);
    rst = 1'b0;
    step_clk(1);
    clear_counts();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b expected 0", cpu_ce); end
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b expected 1", halted); end
    vectors++; if (step_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", step_ack); end
    vectors++; if (cycle_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt); end
    vectors++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL reset_bp: got %b expected 0", bp_hit); end
  endtask

  task automatic test_reset_mid_burst();
    int guard;
    do_reset();
    clkswitch = 1'b1; burst_len = 4'd5; mode = 2'b10; conti = 1'b1;
    guard = 0;
    while (ce_seen < 2 && guard < 200) begin step_clk(1); guard++; end
    vectors++;
    if (ce_seen < 2) begin errors++; $display("FAIL midburst_timeout: got %0d ce expected 2", ce_seen); end
    #1 rst = 1'b1;
    #1;
    vectors++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL async_ce: got %b expected 0", cpu_ce); end
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL async_halted: got %b expected 1", halted); end
    vectors++; if (cycle_cnt !== 4'd0) begin errors++; $display("FAIL async_cnt: got %0d expected 0", cycle_cnt); end
    do_reset();
  endtask

  task automatic test_run();
    do_reset();
    mode = 2'b00;
    step_clk(11);
    mode = 2'b11;
    step_clk(4);
    vectors++; if (ce_seen !== 10) begin errors++; $display("FAIL run_ce_count: got %0d expected 10", ce_seen); end
    vectors++;
    if (ce_seen == 10 && (ce_at[9] - ce_at[0]) !== 9) begin
      errors++; $display("FAIL run_consecutive: got span %0d expected 9", ce_at[9] - ce_at[0]);
    end
    vectors++; if (cycle_cnt !== 4'd10) begin errors++; $display("FAIL run_cnt: got %0d expected 10", cycle_cnt); end
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL run_halted: got %b expected 1", halted); end
  endtask

  task automatic test_step_debounce();
    do_reset();
    mode = 2'b01;
    for (int g = 0; g < 3; g++) press(5, 5);
    vectors++; if (ce_seen !== 0) begin errors++; $display("FAIL glitch_ce: got %0d expected 0", ce_seen); end
    press(40, 40);
    vectors++; if (ce_seen !== 1) begin errors++; $display("FAIL step_ce: got %0d expected 1", ce_seen); end
    vectors++; if (ack_seen !== 1) begin errors++; $display("FAIL step_ack: got %0d expected 1", ack_seen); end
    vectors++; if (cycle_cnt !== 4'd1) begin errors++; $display("FAIL step_cnt: got %0d expected 1", cycle_cnt); end
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL step_halted: got %b expected 1", halted); end
  endtask

  task automatic test_burst_slow();
    do_reset();
    clkswitch = 1'b1; burst_len = 4'd5; mode = 2'b10;
    press(30, 30);
    vectors++; if (ce_seen !== 5) begin errors++; $display("FAIL burst_ce: got %0d expected 5", ce_seen); end
    for (int i = 1; i < ce_at.size(); i++) begin
      vectors++;
      if (ce_at[i] - ce_at[i-1] !== 4) begin
        errors++; $display("FAIL burst_spacing: got %0d expected 4", ce_at[i] - ce_at[i-1]);
      end
    end
    vectors++; if (ack_seen !== 0) begin errors++; $display("FAIL burst_ack: got %0d expected 0", ack_seen); end
    vectors++; if (cycle_cnt !== 4'd5) begin errors++; $display("FAIL burst_cnt: got %0d expected 5", cycle_cnt); end
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL burst_halted: got %b expected 1", halted); end
  endtask

  task automatic test_breakpoint();
    do_reset();
    bp_valid = 1'b1; bp_addr = 32'h10; cpu_pc = 32'h0; mode = 2'b00;
    step_clk(5);
    clear_counts();
    cpu_pc = 32'h10;
    step_clk(5);
`ifdef RUN_CTRL_BREAKPOINT_EN
    vectors++; if (ce_seen !== 0) begin errors++; $display("FAIL bp_ce: got %0d expected 0", ce_seen); end
    vectors++; if (bp_hit !== 1'b1) begin errors++; $display("FAIL bp_hit_set: got %b expected 1", bp_hit); end
    mode = 2'b01;
    step_clk(2);
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL bp_halted: got %b expected 1", halted); end
    clear_counts();
    press(30, 10);
    vectors++; if (ce_seen !== 1) begin errors++; $display("FAIL bp_step_ce: got %0d expected 1", ce_seen); end
    vectors++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL bp_hit_clr: got %b expected 0", bp_hit); end
`else
    vectors++; if (ce_seen !== 5) begin errors++; $display("FAIL nobp_ce: got %0d expected 5", ce_seen); end
    vectors++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL nobp_hit: got %b expected 0", bp_hit); end
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL nobp_halted: got %b expected 0", halted); end
    mode = 2'b11;
    step_clk(3);
`endif
  endtask

  task automatic test_saturate_and_zero_burst();
    do_reset();
    mode = 2'b00;
    step_clk(25);
    mode = 2'b11;
    step_clk(3);
    vectors++; if (ce_seen !== 24) begin errors++; $display("FAIL sat_ce: got %0d expected 24", ce_seen); end
    vectors++; if (cycle_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt: got %0d expected 15", cycle_cnt); end
    clear_counts();
    burst_len = 4'd0; mode = 2'b10;
    press(30, 30);
    vectors++; if (ce_seen !== 0) begin errors++; $display("FAIL zero_burst_ce: got %0d expected 0", ce_seen); end
    vectors++; if (run_seen !== 0) begin errors++; $display("FAIL zero_burst_halted: got %0d unhalted cycles expected 0", run_seen); end
    vectors++; if (cycle_cnt !== 4'hF) begin errors++; $display("FAIL zero_burst_cnt: got %0d expected 15", cycle_cnt); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_run();
    test_step_debounce();
    test_burst_slow();
    test_breakpoint();
    test_saturate_and_zero_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
